ex_hazard_ctrl: RTL and testbench
=================================

Name: ex_hazard_ctrl

Overview:
Pipeline sequencing controller for the EX stage and the multi-cycle multiply/divide unit next to the ALU.
- Detects load-use hazards and multiply/divide structural hazards, and stalls IF/ID while inserting bubbles into ID/EX.
- Squashes younger instructions and redirects the PC when a branch or jump resolves from the EX/MEM register.
- Tracks occupancy of the multiply/divide unit with a latency counter.
- Keeps a saturating stall-cycle performance counter.

Parameters:
MD_LATENCY, 32, cycles a multiply/divide occupies the unit; legal range 1..63.
CNT_W, 6, width of the occupancy counter; must satisfy 2^CNT_W > MD_LATENCY.
PERF_W, 32, width of the stall performance counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
id_rs  in  5  rs field of the instruction in ID.
id_rt  in  5  rt field of the instruction in ID.
id_uses_rt  in  1  instruction in ID reads rt as a source.
id_md_op  in  1  instruction in ID is mult/multu/div/divu.
id_reads_hilo  in  1  instruction in ID is mfhi/mflo.
id_ex_mem_read  in  1  instruction in EX is a load.
id_ex_rt  in  5  destination register of the instruction in EX.
ex_md_start  in  1  instruction in EX is a multiply/divide.
ex_mem_branch  in  1  instruction in MEM is a branch.
ex_mem_alu_zero  in  1  branch condition of the instruction in MEM.
ex_mem_jump  in  1  instruction in MEM is a jump.
stall_if  out  1  hold PC.
stall_id  out  1  hold IF/ID.
bubble_ex  out  1  load a NOP into ID/EX.
flush_if  out  1  squash the instruction in IF.
flush_id  out  1  squash IF/ID.
flush_ex  out  1  squash the EX result going into EX/MEM.
pc_redirect  out  1  PC mux selects the branch/jump target.
md_start_ack  out  1  multiply/divide unit begins an operation this cycle.
md_busy  out  1  multiply/divide unit occupied.
md_done  out  1  one-cycle pulse; HI/LO are written at the end of this cycle.
stall_count  out  PERF_W  saturating count of stall cycles.

Behaviour:
- Clocking and reset:
  - Single clock domain. rst is synchronous, active-high.
  - On rst: md state = MD_IDLE, occupancy counter = 0, stall_count = 0.
  - Combinational outputs evaluate to 0 once state is idle and inputs are inactive.
  - rst mid-operation abandons the operation: no md_done is produced, and md_busy = 0 in the first cycle after the reset edge.
- Redirect (combinational):
  - redirect = ex_mem_jump | (ex_mem_branch & ex_mem_alu_zero).
  - When redirect = 1: pc_redirect = flush_if = flush_id = flush_ex = 1 for exactly that cycle.
- Load-use hazard (combinational):
  - lu = id_ex_mem_read & (id_ex_rt != 0) & ((id_ex_rt == id_rs) | (id_uses_rt & (id_ex_rt == id_rt))).
  - Costs exactly one stall cycle; the next cycle the load is in MEM and forwarding covers it.
- Structural hazard (combinational): sh = md_busy & (id_md_op | id_reads_hilo).
- Stall outputs:
  - stall_if = stall_id = bubble_ex = (lu | sh) & ~redirect.
  - Redirect has priority: the stalled instruction is being squashed anyway.
- Multiply/divide FSM, two states:
  - MD_IDLE:
    - md_start_ack = ex_md_start & ~redirect & ~rst.
    - On ack: counter <= MD_LATENCY-1, next state MD_RUN.
    - If ex_md_start is present during redirect, the op is squashed; state stays MD_IDLE.
  - MD_RUN:
    - md_busy = 1.
    - Counter decrements by 1 each cycle.
    - When counter == 0: md_done = 1 this cycle, next state MD_IDLE.
    - Redirect does not affect MD_RUN (the running op is older than the branch).
  - md_busy is high through and including the md_done cycle, so a dependent mfhi/mflo in ID stalls through the done cycle and proceeds the cycle after.
  - ex_md_start while in MD_RUN cannot occur, because sh holds it in ID; no handling is required.
  - MD_LATENCY = 1: md_busy and md_done are both high in the single cycle after ack.
- Performance counter:
  - stall_count increments by 1 at each clock edge where stall_if = 1.
  - It holds at all-ones (saturates); no wrap.

Test Plan:
1. Load-use: id_ex_mem_read=1, id_ex_rt=5, id_rs=5 -> stall_if/stall_id/bubble_ex = 1 for that cycle. Repeat with id_ex_rt=0 -> all 0. Repeat with id_rt=5, id_uses_rt=0 -> all 0.
2. MD_LATENCY=4: pulse ex_md_start at cycle 0 -> md_start_ack=1 at cycle 0; md_busy=1 in cycles 1-4; md_done=1 only in cycle 4. Hold id_reads_hilo=1 from cycle 1 -> stall cycles 1-4, released in cycle 5, stall_count=4.
3. Branch: ex_mem_branch=1, ex_mem_alu_zero=1 -> pc_redirect and flush_if/id/ex = 1 for one cycle. With alu_zero=0 -> all 0. ex_mem_jump=1 alone -> redirect.
4. Priority: redirect together with lu=1 and ex_md_start=1 -> stalls 0, md_start_ack 0, md_busy stays 0 next cycle.
5. Reset mid-run: MD_LATENCY=8, assert rst at counter=3 -> next cycle md_busy=0, stall_count=0, and md_done never pulses.
6. Saturation: PERF_W=4, 20 consecutive sh stall cycles -> stall_count holds 15.

Source files
------------

// File: rtl/ex_hazard_ctrl.sv
// EX-stage sequencing: load-use and mul/div structural stalls, branch/jump squash
// and redirect, mul/div occupancy tracking, and a saturating stall-cycle counter.
module ex_hazard_ctrl #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6,
  parameter int PERF_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rt,
  input  logic              id_md_op,
  input  logic              id_reads_hilo,
  input  logic              id_ex_mem_read,
  input  logic [4:0]        id_ex_rt,
  input  logic              ex_md_start,
  input  logic              ex_mem_branch,
  input  logic              ex_mem_alu_zero,
  input  logic              ex_mem_jump,
  output logic              stall_if,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic              flush_if,
  output logic              flush_id,
  output logic              flush_ex,
  output logic              pc_redirect,
  output logic              md_start_ack,
  output logic              md_busy,
  output logic              md_done,
  output logic [PERF_W-1:0] stall_count
);

  typedef enum logic {MD_IDLE, MD_RUN} md_state_t;

  md_state_t         state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [PERF_W-1:0] stall_cnt_reg;

  logic redirect;
  logic load_use;
  logic struct_haz;
  logic stall;

  assign redirect = ex_mem_jump | (ex_mem_branch & ex_mem_alu_zero);

  // r0 is hardwired to zero, so a load "into" it never creates a dependency.
  assign load_use = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                    ((id_ex_rt == id_rs) || (id_uses_rt && (id_ex_rt == id_rt)));

  assign md_busy    = (state_reg == MD_RUN);
  assign struct_haz = md_busy & (id_md_op | id_reads_hilo);

  // The stalled instruction is being squashed by a redirect anyway.
  assign stall     = (load_use | struct_haz) & ~redirect;
  assign stall_if  = stall;
  assign stall_id  = stall;
  assign bubble_ex = stall;

  assign pc_redirect = redirect;
  assign flush_if    = redirect;
  assign flush_id    = redirect;
  assign flush_ex    = redirect;

  assign md_start_ack = (state_reg == MD_IDLE) & ex_md_start & ~redirect & ~rst;
  // A reset during the final cycle abandons the op, so HI/LO must not be written.
  assign md_done      = md_busy & (cnt_reg == '0) & ~rst;

  assign stall_count = stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= MD_IDLE;
      cnt_reg       <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (stall && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + PERF_W'(1);

      case (state_reg)
        MD_IDLE: begin
          if (md_start_ack) begin
            cnt_reg   <= CNT_W'(MD_LATENCY - 1);
            state_reg <= MD_RUN;
          end
        end
        MD_RUN: begin
          if (cnt_reg == '0)
            state_reg <= MD_IDLE;
          else
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
        default: state_reg <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: directed scenarios plus random traffic, every cycle
// compared against a remaining-cycles model of the mul/div unit and hazard rules.
module tb_ex_hazard_ctrl;
  localparam int LAT = 4;
  localparam int PW  = 4;
  localparam int SAT = (1 << PW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [4:0]    id_rs, id_rt, id_ex_rt;
  logic          id_uses_rt, id_md_op, id_reads_hilo, id_ex_mem_read;
  logic          ex_md_start, ex_mem_branch, ex_mem_alu_zero, ex_mem_jump;
  logic          stall_if, stall_id, bubble_ex, flush_if, flush_id, flush_ex;
  logic          pc_redirect, md_start_ack, md_busy, md_done;
  logic [PW-1:0] stall_count;

  ex_hazard_ctrl #(.MD_LATENCY(LAT), .CNT_W(6), .PERF_W(PW)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_md_op(id_md_op),
    .id_reads_hilo(id_reads_hilo), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .ex_md_start(ex_md_start), .ex_mem_branch(ex_mem_branch),
    .ex_mem_alu_zero(ex_mem_alu_zero), .ex_mem_jump(ex_mem_jump),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .flush_if(flush_if), .flush_id(flush_id), .flush_ex(flush_ex),
    .pc_redirect(pc_redirect), .md_start_ack(md_start_ack), .md_busy(md_busy),
    .md_done(md_done), .stall_count(stall_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int rem      = 0;   // cycles the mul/div unit still stays busy
  int cnt_mdl  = 0;
  int cyc      = 0;
  int done_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; id_rs = '0; id_rt = '0; id_ex_rt = '0;
    id_uses_rt = 1'b0; id_md_op = 1'b0; id_reads_hilo = 1'b0; id_ex_mem_read = 1'b0;
    ex_md_start = 1'b0; ex_mem_branch = 1'b0; ex_mem_alu_zero = 1'b0; ex_mem_jump = 1'b0;
  endtask

  // Called just after the negedge with inputs applied; returns at the next negedge.
  task automatic cycle();
    bit redir, lu, busy, sh, stall, ack, done;
    #1;
    redir = ex_mem_jump || (ex_mem_branch && ex_mem_alu_zero);
    lu    = id_ex_mem_read && id_ex_rt != 0 &&
            (id_ex_rt == id_rs || (id_uses_rt && id_ex_rt == id_rt));
    busy  = rem > 0;
    sh    = busy && (id_md_op || id_reads_hilo);
    stall = (lu || sh) && !redir;
    ack   = !busy && ex_md_start && !redir && !rst;
    done  = (rem == 1) && !rst;
    check("stall_if", 32'(stall_if), 32'(stall));
    check("stall_id", 32'(stall_id), 32'(stall));
    check("bubble_ex", 32'(bubble_ex), 32'(stall));
    check("pc_redirect", 32'(pc_redirect), 32'(redir));
    check("flush_if", 32'(flush_if), 32'(redir));
    check("flush_id", 32'(flush_id), 32'(redir));
    check("flush_ex", 32'(flush_ex), 32'(redir));
    check("md_start_ack", 32'(md_start_ack), 32'(ack));
    check("md_busy", 32'(md_busy), 32'(busy));
    check("md_done", 32'(md_done), 32'(done));
    check("stall_count", 32'(stall_count), 32'(cnt_mdl));
    if (md_done) done_seen++;
    $display("cyc %0d rst=%0b stall=%0b redir=%0b ack=%0b busy=%0b done=%0b cnt=%0d",
             cyc, rst, stall_if, pc_redirect, md_start_ack, md_busy, md_done, stall_count);
    @(posedge clk);
    if (rst) begin
      rem = 0; cnt_mdl = 0;
    end else begin
      if (stall && cnt_mdl < SAT) cnt_mdl++;
      if (ack) rem = LAT;
      else if (rem > 0) rem--;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs(); rst = 1'b1; cycle(); idle_inputs();
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    // reset state
    #1; check("reset_busy", 32'(md_busy), 32'd0);
    check("reset_count", 32'(stall_count), 32'd0);
    cycle();

    // Load-use: hit, r0 destination, rt not used as a source
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd5; id_rs = 5'd5;
    #1; check("lu_hit", 32'(stall_if), 32'd1);
    cycle();
    id_ex_rt = 5'd0; id_rs = 5'd0;
    #1; check("lu_r0", 32'(stall_if), 32'd0);
    cycle();
    id_ex_rt = 5'd5; id_rs = 5'd1; id_rt = 5'd5; id_uses_rt = 1'b0;
    #1; check("lu_rt_unused", 32'(stall_if), 32'd0);
    cycle();
    id_uses_rt = 1'b1;
    cycle();
    idle_inputs();

    // Mul/div latency with a dependent mfhi held in ID
    do_reset();
    ex_md_start = 1'b1;
    #1; check("md_ack_c0", 32'(md_start_ack), 32'd1);
    cycle();
    ex_md_start = 1'b0; id_reads_hilo = 1'b1;
    repeat (LAT) cycle();
    #1; check("hilo_release", 32'(stall_if), 32'd0);
    check("stall_cnt_4", 32'(stall_count), 32'd4);
    cycle();
    idle_inputs();

    // Redirect: taken branch, not-taken branch, jump
    ex_mem_branch = 1'b1; ex_mem_alu_zero = 1'b1;
    #1; check("br_taken", 32'(pc_redirect), 32'd1);
    cycle();
    ex_mem_alu_zero = 1'b0;
    #1; check("br_not_taken", 32'(flush_ex), 32'd0);
    cycle();
    ex_mem_branch = 1'b0; ex_mem_jump = 1'b1;
    #1; check("jump", 32'(flush_if), 32'd1);
    cycle();

    // Priority: redirect beats load-use and mul/div start
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd7; id_rs = 5'd7; ex_md_start = 1'b1;
    #1; check("prio_stall", 32'(stall_if), 32'd0);
    check("prio_ack", 32'(md_start_ack), 32'd0);
    cycle();
    idle_inputs();
    #1; check("prio_busy", 32'(md_busy), 32'd0);
    cycle();

    // Reset mid-run: no done pulse, busy drops right after the reset edge
    done_seen = 0;
    ex_md_start = 1'b1; cycle(); ex_md_start = 1'b0; id_md_op = 1'b1;
    cycle(); cycle();
    rst = 1'b1; cycle(); rst = 1'b0; id_md_op = 1'b0;
    #1; check("rst_busy", 32'(md_busy), 32'd0);
    check("rst_count", 32'(stall_count), 32'd0);
    repeat (LAT) cycle();
    check("rst_no_done", 32'(done_seen), 32'd0);

    // Saturation: 20 structural stall cycles into a 4-bit counter
    repeat (5) begin
      ex_md_start = 1'b1; id_reads_hilo = 1'b0; cycle();
      ex_md_start = 1'b0; id_reads_hilo = 1'b1;
      repeat (LAT) cycle();
    end
    idle_inputs();
    #1; check("sat_count", 32'(stall_count), 32'(SAT));
    cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst             = ($urandom_range(0, 49) == 0);
      id_rs           = 5'($urandom_range(0, 7));
      id_rt           = 5'($urandom_range(0, 7));
      id_ex_rt        = 5'($urandom_range(0, 7));
      id_uses_rt      = 1'($urandom_range(0, 1));
      id_ex_mem_read  = 1'($urandom_range(0, 1));
      id_md_op        = ($urandom_range(0, 3) == 0);
      id_reads_hilo   = ($urandom_range(0, 3) == 0);
      ex_md_start     = (rem == 0) && ($urandom_range(0, 3) == 0);
      ex_mem_branch   = ($urandom_range(0, 5) == 0);
      ex_mem_alu_zero = 1'($urandom_range(0, 1));
      ex_mem_jump     = ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
